hack_rom_loader: RTL and testbench

HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

---
 rtl/hack_rom_loader.sv | 179 +++++++++++++++++
 tb/tb_hack_rom_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// Byte-stream program loader for a Hack CPU instruction ROM; holds the CPU in reset until a load completes.
// Optional trailing 16-bit checksum is enabled by defining HACK_ROM_LOADER_CHECKSUM_EN.
module hack_rom_loader #(
    parameter int DEPTH = 1024,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic [14:0] pc,
    output logic [15:0] instruction,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        load_done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CSUM_HI,
        CSUM_LO,
        RUN,
        ERROR
    } state_t;

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    localparam state_t POST_DATA = CSUM_HI;
`else
    localparam state_t POST_DATA = RUN;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] sum_q, sum_d;
    logic        rx_ready_q, rx_ready_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        load_done_q, load_done_d;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    logic        err_q, err_d;
`endif

    logic [15:0] rom_q [DEPTH];
    logic        rom_we;
    logic        xfer;
    logic [15:0] rx_word;
    logic        wcnt_in_range;

    function automatic logic accepting(input state_t s);
        return (s == CNT_HI) || (s == CNT_LO) || (s == DATA_HI) || (s == DATA_LO) ||
               (s == CSUM_HI) || (s == CSUM_LO);
    endfunction

    assign xfer          = rx_valid && rx_ready_q;
    assign rx_word       = {hi_q, rx_data};
    assign wcnt_in_range = ({16'd0, wcnt_q} < 32'(DEPTH));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        wcnt_d      = wcnt_q;
        sum_d       = sum_q;
        cpu_rst_n_d = cpu_rst_n_q;
        load_done_d = 1'b0;
        rom_we      = 1'b0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        err_d       = err_q;
`endif
        // A new load request wins over any byte offered in the same cycle.
        if (load_req) begin
            state_d     = CNT_HI;
            wcnt_d      = 16'd0;
            sum_d       = 16'd0;
            cpu_rst_n_d = 1'b0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            err_d       = 1'b0;
`endif
        end else if (xfer) begin
            case (state_q)
                CNT_HI: begin
                    hi_d    = rx_data;
                    state_d = CNT_LO;
                end
                CNT_LO: begin
                    cnt_d   = rx_word;
                    state_d = (rx_word == 16'd0) ? POST_DATA : DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    // Words past the end of the ROM still count and still feed the checksum.
                    rom_we  = wcnt_in_range;
                    wcnt_d  = wcnt_q + 16'd1;
                    sum_d   = sum_q + rx_word;
                    state_d = (wcnt_q + 16'd1 == cnt_q) ? POST_DATA : DATA_HI;
                end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
                CSUM_HI: begin
                    hi_d    = rx_data;
                    state_d = CSUM_LO;
                end
                CSUM_LO: begin
                    if (rx_word == sum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
        if ((state_d == RUN) && (state_q != RUN)) begin
            cpu_rst_n_d = 1'b1;
            load_done_d = 1'b1;
        end
        rx_ready_d = accepting(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            hi_q        <= 8'd0;
            wcnt_q      <= 16'd0;
            sum_q       <= 16'd0;
            rx_ready_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            wcnt_q      <= wcnt_d;
            sum_q       <= sum_d;
            rx_ready_q  <= rx_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            err_q       <= err_d;
`endif
        end
    end

    // ROM has no reset so a program survives both resets and aborted loads.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_q[wcnt_q[AW-1:0]] <= rx_word;
        end
    end

    assign instruction = ({17'd0, pc} < 32'(DEPTH)) ? rom_q[pc[AW-1:0]] : 16'h0000;
    assign rx_ready    = rx_ready_q;
    assign busy        = rx_ready_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign load_done   = load_done_q;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader (DEPTH=4 so the overflow case is reachable).
// Checksum scenarios run only when HACK_ROM_LOADER_CHECKSUM_EN is defined.
module tb_hack_rom_loader;
    localparam int DEPTH = 4;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, load_req, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [14:0] pc;
    logic [15:0] instruction;
    logic        cpu_rst_n, busy, load_done, err;

    int ncheck = 0;
    int nerr = 0;
    int done_cnt = 0;

    hack_rom_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .pc(pc), .instruction(instruction), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int stall);
        int waitc;
        rx_valid = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        waitc    = 0;
        while (rx_ready !== 1'b1 && waitc < 20) begin @(posedge clk); #1; waitc++; end
        if (rx_ready !== 1'b1) begin
            ncheck++; nerr++;
            $display("FAIL handshake_timeout byte=%h rx_ready=%b required=1", b, rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int stall);
        send_byte(w[15:8], stall);
        send_byte(w[7:0], stall);
    endtask

    task automatic send_csum(input logic [15:0] c, input int stall);
        if (CSUM_ON) send_word(c, stall);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = 15'd0;
        repeat (2) @(posedge clk); #1;
        ncheck++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        ncheck++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        ncheck++; if (load_done !== 1'b0) begin nerr++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        ncheck++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        rx_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        rx_valid = 1'b0;
        ncheck++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL idle_rx_ready got=%b exp=0", rx_ready); end
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL idle_cpu_held got=%b exp=0", cpu_rst_n); end
    endtask

    task automatic test_basic_load();
        int d0;
        start_load();
        ncheck++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL basic_rx_ready got=%b exp=1", rx_ready); end
        ncheck++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy got=%b exp=1", busy); end
        d0 = done_cnt;
        send_word(16'h0003, 0);
        send_word(16'hEC10, 0);
        send_word(16'hE308, 0);
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL basic_cpu_held got=%b exp=0", cpu_rst_n); end
        send_word(16'h0000, 0);
        send_csum(16'hCF18, 0);
        ncheck++; if (load_done !== 1'b1) begin nerr++; $display("FAIL basic_load_done got=%b exp=1", load_done); end
        ncheck++; if (cpu_rst_n !== 1'b1) begin nerr++; $display("FAIL basic_cpu_run got=%b exp=1", cpu_rst_n); end
        ncheck++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL basic_run_rx_ready got=%b exp=0", rx_ready); end
        ncheck++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_run_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        ncheck++; if (load_done !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse got=%b exp=0", load_done); end
        ncheck++; if (done_cnt - d0 !== 1) begin nerr++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
        pc = 15'd1; #1;
        ncheck++; if (instruction !== 16'hE308) begin nerr++; $display("FAIL basic_rom1 got=%h exp=e308", instruction); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'hEC10) begin nerr++; $display("FAIL basic_rom0 got=%h exp=ec10", instruction); end
        pc = 15'd2; #1;
        ncheck++; if (instruction !== 16'h0000) begin nerr++; $display("FAIL basic_rom2 got=%h exp=0000", instruction); end
    endtask

    task automatic test_stalls();
        int d0;
        start_load();
        d0 = done_cnt;
        send_word(16'h0003, 5);
        ncheck++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL stall_rx_ready got=%b exp=1", rx_ready); end
        send_word(16'hEC10, 5);
        send_word(16'hE308, 5);
        send_word(16'h0000, 5);
        send_csum(16'hCF18, 5);
        repeat (4) @(posedge clk); #1;
        ncheck++; if (done_cnt - d0 !== 1) begin nerr++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt - d0); end
        ncheck++; if (cpu_rst_n !== 1'b1) begin nerr++; $display("FAIL stall_cpu_run got=%b exp=1", cpu_rst_n); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'hEC10) begin nerr++; $display("FAIL stall_rom0 got=%h exp=ec10", instruction); end
        pc = 15'd1; #1;
        ncheck++; if (instruction !== 16'hE308) begin nerr++; $display("FAIL stall_rom1 got=%h exp=e308", instruction); end
        pc = 15'd2; #1;
        ncheck++; if (instruction !== 16'h0000) begin nerr++; $display("FAIL stall_rom2 got=%h exp=0000", instruction); end
    endtask

    task automatic test_overflow();
        start_load();
        send_word(16'h0006, 0);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        send_word(16'h3333, 0);
        send_word(16'h4444, 0);
        send_word(16'h5555, 0);
        send_word(16'h6666, 0);
        send_csum(16'h6665, 0);
        ncheck++; if (load_done !== 1'b1) begin nerr++; $display("FAIL ovf_load_done got=%b exp=1", load_done); end
        ncheck++; if (cpu_rst_n !== 1'b1) begin nerr++; $display("FAIL ovf_cpu_run got=%b exp=1", cpu_rst_n); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'h1111) begin nerr++; $display("FAIL ovf_rom0 got=%h exp=1111", instruction); end
        pc = 15'd3; #1;
        ncheck++; if (instruction !== 16'h4444) begin nerr++; $display("FAIL ovf_rom3 got=%h exp=4444", instruction); end
        pc = 15'd5; #1;
        ncheck++; if (instruction !== 16'h0000) begin nerr++; $display("FAIL ovf_pc5 got=%h exp=0000", instruction); end
        pc = 15'd4; #1;
        ncheck++; if (instruction !== 16'h0000) begin nerr++; $display("FAIL ovf_pc4 got=%h exp=0000", instruction); end
    endtask

    task automatic test_zero_count();
        start_load();
        send_word(16'h0000, 0);
        send_csum(16'h0000, 0);
        ncheck++; if (load_done !== 1'b1) begin nerr++; $display("FAIL zero_load_done got=%b exp=1", load_done); end
        ncheck++; if (cpu_rst_n !== 1'b1) begin nerr++; $display("FAIL zero_cpu_run got=%b exp=1", cpu_rst_n); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'h1111) begin nerr++; $display("FAIL zero_rom0 got=%h exp=1111", instruction); end
    endtask

    task automatic test_checksum();
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        start_load();
        send_word(16'h0002, 0);
        send_word(16'h0001, 0);
        send_word(16'hFFFF, 0);
        send_word(16'h0000, 0);
        ncheck++; if (load_done !== 1'b1) begin nerr++; $display("FAIL csum_ok_done got=%b exp=1", load_done); end
        ncheck++; if (err !== 1'b0) begin nerr++; $display("FAIL csum_ok_err got=%b exp=0", err); end
        start_load();
        send_word(16'h0002, 0);
        send_word(16'h0001, 0);
        send_word(16'hFFFF, 0);
        send_word(16'h0001, 0);
        ncheck++; if (err !== 1'b1) begin nerr++; $display("FAIL csum_bad_err got=%b exp=1", err); end
        ncheck++; if (load_done !== 1'b0) begin nerr++; $display("FAIL csum_bad_done got=%b exp=0", load_done); end
        repeat (3) @(posedge clk); #1;
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL csum_bad_cpu got=%b exp=0", cpu_rst_n); end
        ncheck++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL csum_bad_rx_ready got=%b exp=0", rx_ready); end
        ncheck++; if (err !== 1'b1) begin nerr++; $display("FAIL csum_err_held got=%b exp=1", err); end
        start_load();
        ncheck++; if (err !== 1'b0) begin nerr++; $display("FAIL csum_err_clear got=%b exp=0", err); end
        send_word(16'h0000, 0);
        send_word(16'h0000, 0);
        ncheck++; if (cpu_rst_n !== 1'b1) begin nerr++; $display("FAIL csum_rerun got=%b exp=1", cpu_rst_n); end
`else
        start_load();
        send_word(16'h0001, 0);
        send_word(16'h1234, 0);
        ncheck++; if (load_done !== 1'b1) begin nerr++; $display("FAIL nocsum_done got=%b exp=1", load_done); end
        ncheck++; if (err !== 1'b0) begin nerr++; $display("FAIL nocsum_err got=%b exp=0", err); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'h1234) begin nerr++; $display("FAIL nocsum_rom0 got=%h exp=1234", instruction); end
`endif
    endtask

    task automatic test_abort_restart();
        ncheck++; if (cpu_rst_n !== 1'b1) begin nerr++; $display("FAIL abort_pre_run got=%b exp=1", cpu_rst_n); end
        start_load();
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL abort_cpu_held got=%b exp=0", cpu_rst_n); end
        send_word(16'h000A, 0);
        send_word(16'hAAAA, 0);
        send_word(16'hBBBB, 0);
        send_word(16'hCCCC, 0);
        load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'hDD;
        @(posedge clk); #1;
        load_req = 1'b0; rx_valid = 1'b0;
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL abort_cpu got=%b exp=0", cpu_rst_n); end
        ncheck++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL abort_rx_ready got=%b exp=1", rx_ready); end
        send_word(16'h0001, 0);
        send_word(16'h7FFF, 0);
        send_csum(16'h7FFF, 0);
        ncheck++; if (load_done !== 1'b1) begin nerr++; $display("FAIL restart_done got=%b exp=1", load_done); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'h7FFF) begin nerr++; $display("FAIL restart_rom0 got=%h exp=7fff", instruction); end
        pc = 15'd1; #1;
        ncheck++; if (instruction !== 16'hBBBB) begin nerr++; $display("FAIL restart_rom1 got=%h exp=bbbb", instruction); end
        pc = 15'd2; #1;
        ncheck++; if (instruction !== 16'hCCCC) begin nerr++; $display("FAIL restart_rom2 got=%h exp=cccc", instruction); end
    endtask

    task automatic test_reset_midload();
        start_load();
        send_word(16'h0002, 0);
        send_byte(8'h12, 0);
        rst = 1'b1; #2;
        ncheck++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL midrst_rx_ready got=%b exp=0", rx_ready); end
        ncheck++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL midrst_cpu got=%b exp=0", cpu_rst_n); end
        ncheck++; if (load_done !== 1'b0) begin nerr++; $display("FAIL midrst_done got=%b exp=0", load_done); end
        ncheck++; if (err !== 1'b0) begin nerr++; $display("FAIL midrst_err got=%b exp=0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (3) @(posedge clk); #1;
        rx_valid = 1'b0;
        ncheck++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL postrst_rx_ready got=%b exp=0", rx_ready); end
        ncheck++; if (cpu_rst_n !== 1'b0) begin nerr++; $display("FAIL postrst_cpu_held got=%b exp=0", cpu_rst_n); end
        pc = 15'd0; #1;
        ncheck++; if (instruction !== 16'h7FFF) begin nerr++; $display("FAIL postrst_rom0 got=%h exp=7fff", instruction); end
        pc = 15'd1; #1;
        ncheck++; if (instruction !== 16'hBBBB) begin nerr++; $display("FAIL postrst_rom1 got=%h exp=bbbb", instruction); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stalls();
        test_overflow();
        test_zero_count();
        test_checksum();
        test_abort_restart();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nerr);
        $finish;
    end
endmodule
